// File: rtl/rc5_pkg.sv
// Shared RC5 key-schedule definitions: default geometry, magic constants and
// the key-mixer state encoding.
package rc5_pkg;

  localparam int W    = 32;
  localparam int T    = 26;
  localparam int C    = 4;
  localparam int LGW  = $clog2(W);
  localparam int ITER = 3 * ((T > C) ? T : C);

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rc5_key_mixer_if.sv
// Key-load request, status and S-table read port of the RC5 key mixer.
interface rc5_key_mixer_if #(
  parameter int W = rc5_pkg::W
);

  logic         start;
  logic [W-1:0] pW;
  logic [W-1:0] qW;
  logic [W-1:0] l0;
  logic [W-1:0] l1;
  logic [W-1:0] l2;
  logic [W-1:0] l3;
  logic         busy;
  logic         done;
  logic [4:0]   s_addr;
  logic [W-1:0] s_data;

  modport master (
    output start, pW, qW, l0, l1, l2, l3, s_addr,
    input  busy, done, s_data
  );

  modport slave (
    input  start, pW, qW, l0, l1, l2, l3, s_addr,
    output busy, done, s_data
  );

endinterface

// File: rtl/rc5_rotl.sv
// Combinational W-bit rotate-left by a variable amount; shared with the
// decrypt datapath.
module rc5_rotl #(
  parameter int W   = 32,
  parameter int LGW = $clog2(W)
) (
  input  logic [W-1:0]   i_data,
  input  logic [LGW-1:0] i_amt,
  output logic [W-1:0]   o_data
);

  logic [2*W-1:0] w_dbl;

  // Shifting a doubled word makes the upper half the rotated result, amount 0 included.
  assign w_dbl  = {i_data, i_data} << i_amt;
  assign o_data = w_dbl[2*W-1:W];

endmodule

// File: rtl/rc5_key_mixer.sv
// RC5 key expansion: fills S from P/Q, mixes it with the key words L, and
// serves S through a registered read port.
module rc5_key_mixer
  import rc5_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  rc5_key_mixer_if.slave bus
);

  localparam int IW = $clog2(T);
  localparam int JW = $clog2(C);
  localparam int SW = $clog2(ITER);
  localparam logic [IW-1:0] LAST_I    = IW'(T - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(ITER - 1);

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_s [T];
  logic [W-1:0]   r_l [C];
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_q;
  logic [IW-1:0]  r_i;
  logic [JW-1:0]  r_j;
  logic [SW-1:0]  r_step;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_sData;

  logic [W-1:0]   w_aSum;
  logic [W-1:0]   w_aNew;
  logic [W-1:0]   w_ab;
  logic [W-1:0]   w_bSum;
  logic [W-1:0]   w_bNew;
  logic [W-1:0]   w_lIn [4];

  assign w_lIn[0] = bus.l0;
  assign w_lIn[1] = bus.l1;
  assign w_lIn[2] = bus.l2;
  assign w_lIn[3] = bus.l3;

  assign w_aSum = r_s[r_i] + r_a + r_b;
  assign w_ab   = w_aNew + r_b;
  assign w_bSum = r_l[r_j] + w_ab;

  rc5_rotl #(.W(W), .LGW(LGW)) u_rotlA (
    .i_data (w_aSum),
    .i_amt  (LGW'(3)),
    .o_data (w_aNew)
  );

  rc5_rotl #(.W(W), .LGW(LGW)) u_rotlB (
    .i_data (w_bSum),
    .i_amt  (w_ab[LGW-1:0]),
    .o_data (w_bNew)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = INIT;
      INIT:    if (r_i == LAST_I) w_nextState = MIX;
      MIX:     if (r_step == LAST_STEP) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      for (int k = 0; k < T; k++) r_s[k] <= '0;
      for (int k = 0; k < C; k++) r_l[k] <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sData <= '0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
      r_done  <= (r_state == DONE);
      // Out-of-range addresses read as zero rather than aliasing into S.
      r_sData <= (bus.s_addr <= LAST_I) ? r_s[bus.s_addr] : '0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc <= bus.pW;
            r_q   <= bus.qW;
            for (int k = 0; k < C; k++) r_l[k] <= w_lIn[k];
            r_i   <= '0;
          end
        end
        INIT: begin
          r_s[r_i] <= r_acc;
          r_acc    <= r_acc + r_q;
          if (r_i == LAST_I) begin
            r_i    <= '0;
            r_j    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_step <= '0;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        MIX: begin
          r_s[r_i] <= w_aNew;
          r_l[r_j] <= w_bNew;
          r_a      <= w_aNew;
          r_b      <= w_bNew;
          r_i      <= (r_i == LAST_I) ? '0 : r_i + 1'b1;
          r_j      <= r_j + 1'b1;
          r_step   <= r_step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.s_data = r_sData;

endmodule

// File: tb/tb_rc5_key_mixer.sv
// Self-checking bench for rc5_key_mixer against a loop-level RC5 key-schedule
// model.
module tb_rc5_key_mixer;
  import rc5_pkg::*;

  typedef logic [31:0] word_t;
  typedef logic [T-1:0][31:0] table_t;
  typedef struct packed {
    word_t            p;
    word_t            q;
    logic [3:0][31:0] k;
    table_t           expS;
  } vec_t;

  localparam int EXP_LAT = 105;
  localparam int NVEC    = 6;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     nChecks = 0;
  int     nErrors = 0;
  vec_t   vecs [NVEC];
  vec_t   vA;
  vec_t   vB;
  int     cyc;

  rc5_key_mixer_if #(.W(32)) bus ();

  rc5_key_mixer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic word_t rotlRef(word_t x, int n);
    int m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic table_t expandRef(word_t p, word_t q, logic [3:0][31:0] key);
    word_t  s [T];
    word_t  l [4];
    word_t  a = 0;
    word_t  b = 0;
    int     i = 0;
    int     j = 0;
    int     iter = 3 * ((T > 4) ? T : 4);
    table_t res;
    for (int n = 0; n < 4; n++) l[n] = key[n];
    s[0] = p;
    for (int n = 1; n < T; n++) s[n] = s[n-1] + q;
    for (int n = 0; n < iter; n++) begin
      s[i] = rotlRef(s[i] + a + b, 3);
      a = s[i];
      l[j] = rotlRef(l[j] + a + b, int'((a + b) % 32));
      b = l[j];
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
    for (int n = 0; n < T; n++) res[n] = s[n];
    return res;
  endfunction

  function automatic vec_t makeVec(word_t p, word_t q, logic [3:0][31:0] key);
    vec_t v;
    v.p    = p;
    v.q    = q;
    v.k    = key;
    v.expS = expandRef(p, q, key);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.pW    = v.p;
    bus.qW    = v.q;
    bus.l0    = v.k[0];
    bus.l1    = v.k[1];
    bus.l2    = v.k[2];
    bus.l3    = v.k[3];
    bus.start = 1'b1;
  endtask

  // Counts edges since acceptance until done shows; an overrun reports -1.
  task automatic waitDone(input int fromCount, output int cycles);
    int n = fromCount;
    while (!bus.done && n < 300) begin
      tick();
      n++;
    end
    cycles = bus.done ? n : -1;
  endtask

  task automatic readAll(input string tag, input table_t exp);
    for (int a = 0; a < T; a++) begin
      bus.s_addr = 5'(a);
      tick();
      checkOutput($sformatf("%s S[%0d]", tag, a), bus.s_data, exp[a]);
    end
  endtask

  task automatic runCase(input string tag, input vec_t v);
    applyStimulus(v);
    tick();
    bus.start = 1'b0;
    checkOutput({tag, " busy after accept"}, word_t'(bus.busy), 32'd1);
    waitDone(0, cyc);
    checkOutput({tag, " done latency"}, word_t'(cyc), word_t'(EXP_LAT));
    checkOutput({tag, " busy at done"}, word_t'(bus.busy), 32'd0);
    tick();
    checkOutput({tag, " done pulse width"}, word_t'(bus.done), 32'd0);
    readAll(tag, v.expS);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.pW     = '0;
    bus.qW     = '0;
    bus.l0     = '0;
    bus.l1     = '0;
    bus.l2     = '0;
    bus.l3     = '0;
    bus.s_addr = '0;

    vecs[0]      = makeVec(32'h0, 32'h0, '0);
    vecs[0].expS = '0;
    vecs[1]      = makeVec(P32, Q32, '0);
    vecs[2]      = makeVec(P32, Q32, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
    for (int n = 3; n < NVEC; n++)
      vecs[n] = makeVec($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});

    rst = 1'b0;
    tick();
    tick();
    checkOutput("reset busy", word_t'(bus.busy), 32'd0);
    checkOutput("reset done", word_t'(bus.done), 32'd0);
    checkOutput("reset s_data", bus.s_data, 32'd0);
    rst = 1'b1;
    tick();

    // INIT-phase read of S[1], including the same-edge write returning the old value.
    applyStimulus(vecs[1]);
    bus.s_addr = 5'd1;
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("init S[1] at E0+1", bus.s_data, 32'h0);
    tick();
    checkOutput("init S[1] at E0+2 old", bus.s_data, 32'h0);
    tick();
    checkOutput("init S[1] at E0+3", bus.s_data, 32'h5618CB1C);
    waitDone(3, cyc);
    checkOutput("probe done latency", word_t'(cyc), word_t'(EXP_LAT));
    readAll("probe", vecs[1].expS);

    bus.s_addr = 5'd26;
    tick();
    checkOutput("addr 26 reads zero", bus.s_data, 32'h0);
    bus.s_addr = 5'd31;
    tick();
    checkOutput("addr 31 reads zero", bus.s_data, 32'h0);

    for (int n = 0; n < NVEC; n++) runCase($sformatf("vec%0d", n), vecs[n]);

    // start held high while the inputs change mid-run.
    vA = makeVec($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    vB = makeVec($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    applyStimulus(vA);
    tick();
    for (int n = 0; n < 40; n++) tick();
    applyStimulus(vB);
    waitDone(40, cyc);
    checkOutput("held done latency", word_t'(cyc), word_t'(EXP_LAT));
    checkOutput("held busy at done", word_t'(bus.busy), 32'd0);
    for (int a = 0; a < T; a++) begin
      bus.s_addr = 5'(a);
      tick();
      if (a == 0) begin
        checkOutput("held restart busy", word_t'(bus.busy), 32'd1);
        checkOutput("held restart done low", word_t'(bus.done), 32'd0);
      end
      checkOutput($sformatf("held first S[%0d]", a), bus.s_data, vA.expS[a]);
    end
    bus.start = 1'b0;
    waitDone(T - 1, cyc);
    checkOutput("held second latency", word_t'(cyc), word_t'(EXP_LAT));
    tick();
    readAll("held second", vB.expS);

    // Reset in the middle of the mixing pass.
    applyStimulus(vecs[2]);
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 49; n++) tick();
    rst = 1'b0;
    tick();
    checkOutput("midmix reset busy", word_t'(bus.busy), 32'd0);
    checkOutput("midmix reset done", word_t'(bus.done), 32'd0);
    checkOutput("midmix reset s_data", bus.s_data, 32'h0);
    rst = 1'b1;
    readAll("after reset", '0);
    runCase("post reset", vecs[3]);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
